sram_bus_slave: RTL and testbench

- Single-port synchronous SRAM slave on the core's data/instruction bus (bstart/bdone handshake, ttype, tsize, addr, wdata, rdata).
- Sits directly downstream of the core's dbus or ibus master port. Two instances give the core separate I- and D-memories with no structural hazard.
- Handles byte, half and word access with byte lanes and right-justified read data. Provides programmable wait states and error signalling for misaligned, out-of-range or reserved-size requests.

---
 rtl/sram_bus_slave.sv | 173 +++++++++++++++++
 tb/tb_sram_bus_slave.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_bus_slave.sv
// Single-port SRAM slave for the core's bstart/bdone bus: byte/half/word access with byte lanes,
// programmable wait states and error signalling for misaligned, out-of-range or reserved requests.
module sram_bus_slave #(
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter int unsigned WAIT_STATES = 0,
    parameter string       INIT_FILE   = ""
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        breq,
    input  logic        bstart,
    input  logic        ttype,
    input  logic [1:0]  tsize,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        bdone,
    output logic        berr
);

    localparam int unsigned IdxW      = $clog2(DEPTH_WORDS);
    localparam logic [32:0] SpanBytes = 33'(DEPTH_WORDS) * 33'd4;
    localparam logic [3:0]  WaitInit  = (WAIT_STATES == 0) ? 4'd0 : 4'(WAIT_STATES - 1);

    typedef enum logic [1:0] {StIdle, StWait, StDone} state_e;

    state_e      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [1:0]  tsize_q, tsize_d;
    logic        ttype_q, ttype_d;
    logic [31:0] rdata_q, rdata_d;
    logic        bdone_q, bdone_d;
    logic        berr_q, berr_d;

    logic [31:0] mem [DEPTH_WORDS];

    logic            enter_done;
    logic [31:0]     req_addr, req_wdata;
    logic [1:0]      req_tsize;
    logic            req_ttype;
    logic [31:0]     off;
    logic            out_of_range, req_err;
    logic [1:0]      lane;
    logic [IdxW-1:0] idx;
    logic [3:0]      be;
    logic [31:0]     wrep;
    logic [31:0]     word;
    logic [15:0]     lane_data;
    logic            mem_we;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        tsize_d    = tsize_q;
        ttype_d    = ttype_q;
        enter_done = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (breq && bstart) begin
                    addr_d  = addr;
                    wdata_d = wdata;
                    tsize_d = tsize;
                    ttype_d = ttype;
                    if (WAIT_STATES > 0) begin
                        state_d = StWait;
                        cnt_d   = WaitInit;
                    end else begin
                        state_d    = StDone;
                        enter_done = 1'b1;
                    end
                end
            end
            StWait: begin
                if (cnt_q == 4'd0) begin
                    state_d    = StDone;
                    enter_done = 1'b1;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // With zero wait states the access happens on the capture edge, so use the live inputs.
    always_comb begin
        req_addr  = (state_q == StIdle) ? addr  : addr_q;
        req_wdata = (state_q == StIdle) ? wdata : wdata_q;
        req_tsize = (state_q == StIdle) ? tsize : tsize_q;
        req_ttype = (state_q == StIdle) ? ttype : ttype_q;

        off          = req_addr - BASE_ADDR;
        out_of_range = (req_addr < BASE_ADDR) || ({1'b0, off} >= SpanBytes);
        req_err      = out_of_range || (req_tsize == 2'b11) ||
                       (req_tsize == 2'b01 && req_addr[0]) ||
                       (req_tsize == 2'b10 && req_addr[1:0] != 2'b00);
        lane         = req_addr[1:0];
        idx          = off[IdxW+1:2];

        case (req_tsize)
            2'b00:   be = 4'b0001 << lane;
            2'b01:   be = 4'b0011 << lane;
            default: be = 4'b1111;
        endcase
        case (req_tsize)
            2'b00:   wrep = {4{req_wdata[7:0]}};
            2'b01:   wrep = {2{req_wdata[15:0]}};
            default: wrep = req_wdata;
        endcase

        word      = mem[idx];
        lane_data = 16'(word >> {lane, 3'b000});
        mem_we    = rst_n && enter_done && req_ttype && !req_err;

        rdata_d = rdata_q;
        if (enter_done) begin
            if (req_err) begin
                rdata_d = 32'd0;
            end else if (!req_ttype) begin
                case (req_tsize)
                    2'b00:   rdata_d = {24'd0, lane_data[7:0]};
                    2'b01:   rdata_d = {16'd0, lane_data};
                    default: rdata_d = word;
                endcase
            end
        end
        bdone_d = enter_done;
        berr_d  = enter_done && req_err;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            cnt_q   <= 4'd0;
            addr_q  <= 32'd0;
            wdata_q <= 32'd0;
            tsize_q <= 2'd0;
            ttype_q <= 1'b0;
            rdata_q <= 32'd0;
            bdone_q <= 1'b0;
            berr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            tsize_q <= tsize_d;
            ttype_q <= ttype_d;
            rdata_q <= rdata_d;
            bdone_q <= bdone_d;
            berr_q  <= berr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int i = 0; i < 4; i++) begin
                if (be[i]) mem[idx][8*i +: 8] <= wrep[8*i +: 8];
            end
        end
    end

    assign rdata = rdata_q;
    assign bdone = bdone_q;
    assign berr  = berr_q;

endmodule

// File: tb/tb_sram_bus_slave.sv
// Scoreboard bench for sram_bus_slave: one instance with no wait states, one with three,
// driven by directed and random traffic checked against a byte-level memory model.
module tb_sram_bus_slave;

    localparam int unsigned Depth = 64;
    localparam logic [31:0] Base  = 32'h0000_0000;

    typedef struct {
        logic        err;
        logic [31:0] rd;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        breq [2];
    logic        bstart [2];
    logic        ttype [2];
    logic [1:0]  tsize [2];
    logic [31:0] addr [2];
    logic [31:0] wdata [2];
    logic [31:0] rdata [2];
    logic        bdone [2];
    logic        berr [2];

    int unsigned ws [2] = '{0, 3};
    exp_t        sb0[$];
    exp_t        sb1[$];
    logic [31:0] mdl_mem [2][Depth];
    logic [31:0] mdl_rd [2];
    int          n_checks = 0;
    int          n_pass = 0;

    always #5 clk = ~clk;

    sram_bus_slave #(
        .BASE_ADDR(Base), .DEPTH_WORDS(Depth), .WAIT_STATES(0), .INIT_FILE("")
    ) dut0 (
        .clk(clk), .rst_n(rst_n), .breq(breq[0]), .bstart(bstart[0]), .ttype(ttype[0]),
        .tsize(tsize[0]), .addr(addr[0]), .wdata(wdata[0]), .rdata(rdata[0]),
        .bdone(bdone[0]), .berr(berr[0])
    );

    sram_bus_slave #(
        .BASE_ADDR(Base), .DEPTH_WORDS(Depth), .WAIT_STATES(3), .INIT_FILE("")
    ) dut3 (
        .clk(clk), .rst_n(rst_n), .breq(breq[1]), .bstart(bstart[1]), .ttype(ttype[1]),
        .tsize(tsize[1]), .addr(addr[1]), .wdata(wdata[1]), .rdata(rdata[1]),
        .bdone(bdone[1]), .berr(berr[1])
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
    endtask

    // Reference: memory as bytes, errors from the address/size rules, rdata cleared on error.
    task automatic model(input int d, input logic tt, input logic [1:0] ts,
                         input logic [31:0] a, input logic [31:0] wd);
        exp_t        e;
        logic        err;
        logic [31:0] w, v;
        int          off, nb, idx;
        err = (a < Base) || (longint'(a) >= longint'(Base) + 4 * longint'(Depth)) ||
              (ts == 2'd3) || (ts == 2'd1 && a % 2 != 0) || (ts == 2'd2 && a % 4 != 0);
        if (err) begin
            mdl_rd[d] = 32'd0;
        end else begin
            nb  = 1 << ts;
            idx = int'((a - Base) / 4);
            off = int'(a % 4);
            w   = mdl_mem[d][idx];
            if (tt) begin
                for (int k = 0; k < nb; k++) w[8*(off+k) +: 8] = wd[8*k +: 8];
                mdl_mem[d][idx] = w;
            end else begin
                v = 32'd0;
                for (int k = 0; k < nb; k++) v[8*k +: 8] = w[8*(off+k) +: 8];
                mdl_rd[d] = v;
            end
        end
        e.err = err;
        e.rd  = mdl_rd[d];
        if (d == 0) sb0.push_back(e);
        else sb1.push_back(e);
    endtask

    // Called at posedge+1; returns at posedge+1 of the bdone cycle with bstart still high.
    task automatic do_txn(input int d, input logic tt, input logic [1:0] ts,
                          input logic [31:0] a, input logic [31:0] wd);
        int n;
        model(d, tt, ts, a, wd);
        ttype[d]  = tt;
        tsize[d]  = ts;
        addr[d]   = a;
        wdata[d]  = wd;
        breq[d]   = 1'b1;
        bstart[d] = 1'b1;
        if (bdone[d]) begin
            @(posedge clk);
            #1;
        end
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (!bdone[d] && n < 40);
        chk($sformatf("dut%0d.latency", d), 32'(n), 32'(ws[d] + 1));
    endtask

    task automatic release_bus(input int d, input int gap);
        @(posedge clk);
        #1;
        breq[d]   = 1'b0;
        bstart[d] = 1'b0;
        repeat (gap) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk_reset_outputs();
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("dut%0d.rst_rdata", d), rdata[d], 32'd0);
            chk($sformatf("dut%0d.rst_bdone", d), 32'(bdone[d]), 32'd0);
            chk($sformatf("dut%0d.rst_berr", d), 32'(berr[d]), 32'd0);
        end
    endtask

    task automatic random_traffic(input int d, input int count);
        logic [1:0]  ts;
        logic [31:0] a;
        logic        busy;
        busy = 1'b0;
        for (int i = 0; i < count; i++) begin
            ts = 2'($urandom_range(0, 2));
            a  = 4 * $urandom_range(0, Depth - 1);
            if (ts == 2'd0) a = a + $urandom_range(0, 3);
            if (ts == 2'd1) a = a + 2 * $urandom_range(0, 1);
            if ($urandom_range(0, 15) == 0) a = a + 4 * Depth;
            if ($urandom_range(0, 23) == 0) ts = 2'd3;
            do_txn(d, 1'($urandom_range(0, 1)), ts, a, $urandom);
            if ($urandom_range(0, 2) != 0) release_bus(d, $urandom_range(0, 2));
        end
        release_bus(d, 2);
    endtask

    always @(negedge clk) begin : monitor
        exp_t e;
        logic have;
        for (int d = 0; d < 2; d++) begin
            if (bdone[d]) begin
                have = (d == 0) ? (sb0.size() != 0) : (sb1.size() != 0);
                chk($sformatf("dut%0d.bdone_expected", d), 32'(have), 32'd1);
                if (have) begin
                    e = (d == 0) ? sb0.pop_front() : sb1.pop_front();
                    chk($sformatf("dut%0d.berr", d), 32'(berr[d]), 32'(e.err));
                    chk($sformatf("dut%0d.rdata", d), rdata[d], e.rd);
                end
            end else begin
                chk($sformatf("dut%0d.berr_idle", d), 32'(berr[d]), 32'd0);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation still running at %0t, expected $finish earlier", $time);
        $fatal(1);
    end

    initial begin
        for (int d = 0; d < 2; d++) begin
            breq[d] = 1'b0; bstart[d] = 1'b0; ttype[d] = 1'b0;
            tsize[d] = 2'd0; addr[d] = 32'd0; wdata[d] = 32'd0; mdl_rd[d] = 32'd0;
        end
        #2 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk_reset_outputs();
        @(posedge clk);
        #1 rst_n = 1'b1;

        // No wait states: word, lane and error cases
        do_txn(0, 1'b1, 2'd2, 32'h10, 32'hDEAD_BEEF); release_bus(0, 0);
        do_txn(0, 1'b0, 2'd2, 32'h10, 32'd0);         release_bus(0, 1);
        do_txn(0, 1'b1, 2'd2, 32'h10, 32'h1122_3344); release_bus(0, 0);
        do_txn(0, 1'b1, 2'd0, 32'h12, 32'h0000_00AA); release_bus(0, 0);
        do_txn(0, 1'b0, 2'd2, 32'h10, 32'd0);         release_bus(0, 0);
        do_txn(0, 1'b0, 2'd0, 32'h13, 32'd0);         release_bus(0, 0);
        do_txn(0, 1'b0, 2'd1, 32'h12, 32'd0);         release_bus(0, 0);
        do_txn(0, 1'b1, 2'd1, 32'h10, 32'hFFFF_BEEF); release_bus(0, 0);
        do_txn(0, 1'b0, 2'd2, 32'h10, 32'd0);         release_bus(0, 0);
        do_txn(0, 1'b0, 2'd1, 32'h11, 32'd0);         release_bus(0, 0);
        do_txn(0, 1'b1, 2'd2, 32'h12, 32'hFFFF_FFFF); release_bus(0, 0);
        do_txn(0, 1'b0, 2'd3, 32'h10, 32'd0);         release_bus(0, 0);
        do_txn(0, 1'b1, 2'd2, 4 * Depth, 32'h5555_5555); release_bus(0, 0);
        do_txn(0, 1'b0, 2'd2, 32'h10, 32'd0);         release_bus(0, 2);

        // Three wait states: back-to-back restart after DONE, then bstart held into DONE
        do_txn(1, 1'b1, 2'd2, 32'h10, 32'hA5A5_5A5A);
        do_txn(1, 1'b0, 2'd2, 32'h10, 32'd0);
        release_bus(1, 4);

        // Reset during WAIT abandons the write
        do_txn(1, 1'b1, 2'd2, 32'h20, 32'hCAFE_F00D); release_bus(1, 2);
        ttype[1] = 1'b1; tsize[1] = 2'd2; addr[1] = 32'h20; wdata[1] = 32'h1234_5678;
        breq[1] = 1'b1; bstart[1] = 1'b1;
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        rst_n = 1'b0;
        breq[1] = 1'b0; bstart[1] = 1'b0;
        repeat (2) begin
            @(negedge clk);
            chk_reset_outputs();
        end
        @(posedge clk);
        #1 rst_n = 1'b1;
        mdl_rd[0] = 32'd0;
        mdl_rd[1] = 32'd0;
        repeat (6) begin
            @(posedge clk);
            #1;
        end
        do_txn(1, 1'b0, 2'd2, 32'h20, 32'd0); release_bus(1, 1);

        // Core-style traffic: fetch of 0, preload every word, then a random load/store mix
        for (int d = 0; d < 2; d++) begin
            do_txn(d, 1'b0, 2'd2, 32'h0, 32'd0); release_bus(d, 0);
            for (int i = 0; i < Depth; i++) begin
                do_txn(d, 1'b1, 2'd2, 32'(4 * i), $urandom);
                if (i % 3 == 0) release_bus(d, 0);
            end
            release_bus(d, 1);
            random_traffic(d, 100);
        end

        repeat (6) @(posedge clk);
        chk("scoreboard_drained", 32'(sb0.size() + sb1.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
